// File: rtl/float_argminmax_tree_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Package  : float_pkg
//  Purpose  : Shared entry type, mode encoding and float helpers for the
//             arg-min/arg-max reduction tree.
//  Revision : 1.0 - initial release
// ============================================================================
package float_pkg;

    // Entries are sized for the widest supported format/lane count; narrower
    // configurations zero-extend and the unused upper bits are optimised away.
    localparam int c_MAX_SIZE  = 64;
    localparam int c_MAX_IDX_W = 16;

    typedef enum logic {
        MODE_MIN = 1'b0,
        MODE_MAX = 1'b1
    } argmm_mode_t;

    typedef struct packed {
        logic [c_MAX_SIZE-1:0]  value;
        logic [c_MAX_IDX_W-1:0] index;
        logic                   is_nan;
    } argmm_entry_t;

    function automatic int mant_width(input int size, input int exp_w);
        return size - 1 - exp_w;
    endfunction

    function automatic logic is_nan(input logic [c_MAX_SIZE-1:0] word,
                                    input int size, input int exp_w);
        logic exp_ones;
        logic man_nz;
        exp_ones = 1'b1;
        man_nz   = 1'b0;
        for (int i = 0; i < c_MAX_SIZE; i++) begin
            if (i < mant_width(size, exp_w))
                man_nz = man_nz | word[i];
            else if (i < size - 1)
                exp_ones = exp_ones & word[i];
        end
        return exp_ones && man_nz;
    endfunction

    // Number of surviving entries after lvl pairing rounds of n lanes.
    function automatic int level_width(input int n, input int lvl);
        int w;
        w = n;
        for (int i = 0; i < lvl; i++)
            w = (w + 1) / 2;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/float_argminmax_tree_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Interface : float_argminmax_tree_if
//  Purpose   : Input vector stream and result stream of the reduction tree.
//  Revision  : 1.0 - initial release
// ============================================================================
interface float_argminmax_tree_if #(
    parameter int N    = 16,
    parameter int SIZE = 64
);
    localparam int IDX_W = $clog2(N);

    logic [N-1:0][SIZE-1:0] s_axis_a_tdata;
    logic                   s_axis_a_tuser;
    logic                   s_axis_a_tvalid;
    logic                   s_axis_a_tready;

    logic [IDX_W-1:0]       m_axis_result_tdata;
    logic [SIZE-1:0]        m_axis_result_value;
    logic                   m_axis_result_tuser;
    logic                   m_axis_result_tvalid;
    logic                   m_axis_result_tready;

    modport slave (
        input  s_axis_a_tdata, s_axis_a_tuser, s_axis_a_tvalid, m_axis_result_tready,
        output s_axis_a_tready, m_axis_result_tdata, m_axis_result_value,
               m_axis_result_tuser, m_axis_result_tvalid
    );

    modport master (
        output s_axis_a_tdata, s_axis_a_tuser, s_axis_a_tvalid, m_axis_result_tready,
        input  s_axis_a_tready, m_axis_result_tdata, m_axis_result_value,
               m_axis_result_tuser, m_axis_result_tvalid
    );
endinterface
`default_nettype wire

// File: rtl/float_argminmax_tree_cmp_sel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : float_cmp_sel
//  Purpose  : Combinational compare-select of one lane pair; a is the lower
//             index and keeps every tie.
//  Revision : 1.0 - initial release
// ============================================================================
module float_cmp_sel
    import float_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  argmm_entry_t i_a,
    input  argmm_entry_t i_b,
    input  argmm_mode_t  i_mode,
    output argmm_entry_t o_win
);

    logic [SIZE-1:0] w_key_a;
    logic [SIZE-1:0] w_key_b;
    logic            w_both_zero;
    logic            w_b_wins;

    // Maps sign-magnitude words onto an unsigned total order.
    function automatic logic [SIZE-1:0] order_key(input logic [SIZE-1:0] x);
        return x[SIZE-1] ? ~x : {1'b1, x[SIZE-2:0]};
    endfunction

    always_comb begin
        w_key_a     = order_key(i_a.value[SIZE-1:0]);
        w_key_b     = order_key(i_b.value[SIZE-1:0]);
        w_both_zero = (i_a.value[SIZE-2:0] == '0) && (i_b.value[SIZE-2:0] == '0);
        w_b_wins    = 1'b0;
        if (i_a.is_nan)
            w_b_wins = !i_b.is_nan;
        else if (i_b.is_nan || w_both_zero)
            w_b_wins = 1'b0;
        else if (i_mode == MODE_MIN)
            w_b_wins = (w_key_b < w_key_a);
        else
            w_b_wins = (w_key_b > w_key_a);

        o_win        = w_b_wins ? i_b : i_a;
        o_win.is_nan = i_a.is_nan && i_b.is_nan;
    end

endmodule
`default_nettype wire

// File: rtl/float_argminmax_tree.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : float_argminmax_tree
//  Purpose  : Pipelined N-way float arg-min/arg-max tree with AXI-Stream
//             handshake; one pairing level per register stage.
//  Revision : 1.0 - initial release
// ============================================================================
module float_argminmax_tree
    import float_pkg::*;
#(
    parameter int N     = 16,
    parameter int SIZE  = 64,
    parameter int EXP_W = 11
) (
    input  wire logic               aclk,
    input  wire logic               aresetn,
    float_argminmax_tree_if.slave   bus
);

    localparam int IDX_W  = $clog2(N);
    localparam int LEVELS = $clog2(N);

    argmm_entry_t      w_src [LEVELS][N];
    argmm_entry_t      w_win [LEVELS][N];
    argmm_entry_t      r_lvl [LEVELS][N];
    logic [LEVELS-1:0] r_valid;
    logic [LEVELS-1:0] r_mode;
    logic [LEVELS-1:0] w_valid_src;
    logic [LEVELS-1:0] w_mode_src;
    logic [LEVELS:0]   w_ready;

    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int c_W_IN = level_width(N, k);
        for (genvar j = 0; j < N; j++) begin : g_lane
            if (k == 0) begin : g_in
                assign w_src[k][j] = '{
                    value:  c_MAX_SIZE'(bus.s_axis_a_tdata[j]),
                    index:  c_MAX_IDX_W'(j),
                    is_nan: is_nan(c_MAX_SIZE'(bus.s_axis_a_tdata[j]), SIZE, EXP_W)
                };
            end else begin : g_reg
                assign w_src[k][j] = r_lvl[k-1][j];
            end

            if (2*j + 1 < c_W_IN) begin : g_pair
                float_cmp_sel #(.SIZE(SIZE)) u_cmp (
                    .i_a    (w_src[k][2*j]),
                    .i_b    (w_src[k][2*j+1]),
                    .i_mode (argmm_mode_t'(w_mode_src[k])),
                    .o_win  (w_win[k][j])
                );
            end else if (2*j < c_W_IN) begin : g_pass
                // Odd trailing entry rides through this level uncompared.
                assign w_win[k][j] = w_src[k][2*j];
            end else begin : g_idle
                assign w_win[k][j] = '0;
            end
        end
    end

    always_comb begin
        w_ready        = '0;
        w_valid_src    = '0;
        w_mode_src     = '0;
        w_ready[LEVELS] = bus.m_axis_result_tready;
        for (int k = LEVELS - 1; k >= 0; k--)
            w_ready[k] = !r_valid[k] || w_ready[k+1];
        w_valid_src[0] = bus.s_axis_a_tvalid;
        w_mode_src[0]  = bus.s_axis_a_tuser;
        for (int k = 1; k < LEVELS; k++) begin
            w_valid_src[k] = r_valid[k-1];
            w_mode_src[k]  = r_mode[k-1];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_valid <= '0;
            r_mode  <= '0;
            for (int k = 0; k < LEVELS; k++)
                for (int j = 0; j < N; j++)
                    r_lvl[k][j] <= '0;
        end else begin
            for (int k = 0; k < LEVELS; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_valid_src[k];
                    r_mode[k]  <= w_mode_src[k];
                    for (int j = 0; j < N; j++)
                        r_lvl[k][j] <= w_win[k][j];
                end
            end
        end
    end

    assign bus.s_axis_a_tready      = aresetn && w_ready[0];
    assign bus.m_axis_result_tvalid = r_valid[LEVELS-1];
    assign bus.m_axis_result_tdata  = r_lvl[LEVELS-1][0].index[IDX_W-1:0];
    assign bus.m_axis_result_value  = r_lvl[LEVELS-1][0].value[SIZE-1:0];
    assign bus.m_axis_result_tuser  = r_lvl[LEVELS-1][0].is_nan;

endmodule
`default_nettype wire

// File: doc/float_argminmax_tree.md
Name: float_argminmax_tree

Overview:
- Pipelined N-way floating-point arg-min/arg-max reduction tree on AXI-Stream; the parametrised successor to the fixed 16-input argmin tree.
- Channel count, float format and per-transaction min/max mode are selectable. NaN handling and tie-breaking are deterministic.
- Returns both the winning index and the winning value.
- Sits between vector-producing float datapaths (distance/score units) and index consumers, for example a classifier select or a nearest-neighbour pick.

Parameters:
- N, 16, number of input lanes; any integer >= 2, power of two not required.
- SIZE, 64, float word width in bits (IEEE-754 layout).
- EXP_W, 11, exponent field width; mantissa width = SIZE-1-EXP_W.
- IDX_W (localparam), $clog2(N), index width.
- LEVELS (localparam), $clog2(N), number of tree stages and the latency in cycles.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_a_tdata  in  N*SIZE  packed [N-1:0][SIZE-1:0] input vector; lane i carries index i
- s_axis_a_tuser  in  1  mode: 0 = argmin, 1 = argmax
- s_axis_a_tvalid  in  1  input valid
- s_axis_a_tready  out  1  input ready
- m_axis_result_tdata  out  IDX_W  winning lane index
- m_axis_result_value  out  SIZE  winning lane value
- m_axis_result_tuser  out  1  all-NaN flag: 1 when every input lane was NaN
- m_axis_result_tvalid  out  1  result valid
- m_axis_result_tready  in  1  downstream ready

Behaviour:
- Reset (aresetn low, asynchronous):
  - All stage valid bits and data/index registers clear to 0.
  - m_axis_result_tvalid = 0, m_axis_result_tdata = 0, m_axis_result_value = 0, m_axis_result_tuser = 0.
  - s_axis_a_tready is forced 0 while aresetn is low.
  - Reset mid-operation discards all in-flight vectors; no partial results are emitted after release.
- Pipeline structure:
  - LEVELS register stages. Stage k pairs adjacent entries of stage k-1 (lanes 2j and 2j+1).
  - An odd trailing entry passes through registered, uncompared.
  - Each entry carries {value, index, nan flag}. The mode bit travels with its vector through every stage.
- Handshake:
  - Each stage has one valid bit and a common ready chain: ready_k = !valid_k || ready_{k+1}, where ready_{LEVELS} = m_axis_result_tready.
  - s_axis_a_tready = ready_0 (gated by aresetn).
  - A transfer occurs on tvalid && tready. Stages advance only when their ready is high.
  - Throughput is 1 vector/cycle with no bubbles when downstream is always ready.
  - Output data is stable while tvalid is high and tready is low.
  - tvalid never drops without a transfer.
- Latency: an input accepted at cycle t, with downstream always ready, appears with m_axis_result_tvalid = 1 at cycle t+LEVELS.
- Compare rule (combinational, per pair a = lower index, b = higher index):
  - NaN test: exponent all ones and mantissa != 0.
  - If exactly one operand is NaN, the non-NaN operand wins.
  - If both are NaN, a wins.
  - Otherwise values are ordered by IEEE magnitude using sign-magnitude ordering; -0 and +0 compare equal.
  - Infinities are ordinary extreme values.
  - Mode 0: b wins only if b < a. Mode 1: b wins only if b > a.
  - Ties therefore always go to the lower index.
- Winning entry's nan flag = a.nan && b.nan. The final flag drives m_axis_result_tuser; the index in that case is 0.
- Denormals are compared by bit pattern (no flush); this is correct under sign-magnitude ordering.

Decomposition:
- Package float_pkg:
  - typedef argmm_entry_t {value, index, is_nan}.
  - Function is_nan(word, EXP_W).
  - Localparam helpers for mantissa width.
- Sub-module float_cmp_sel:
  - Combinational pair compare-select.
  - Inputs: two entries and mode. Output: winning entry.
  - Instantiated by generate loops per level.
- Stage registers and the ready chain live in the top module.

Test Plan:
1. N=16, SIZE=64, mode 0, lanes = 16 distinct positive doubles with minimum 0.5 at lane 11:
   - Result index 11, value 64'h3FE0000000000000, tuser 0.
   - Result arrives exactly 4 cycles after acceptance.
2. Mode 1 on the same vector with maximum 1e6 at lane 3, plus ties -1.0 at lanes 2 and 9 under mode 0 with all other lanes positive:
   - Index 3 in mode 1.
   - Index 2 in mode 0 (lower index wins the tie).
   - +0/-0 tie between lanes 5 and 6 resolves to 5.
3. NaN handling:
   - Lanes 0–14 are qNaN 64'h7FF8000000000000 and lane 15 = +Inf, mode 0: index 15.
   - All 16 lanes NaN: index 0, tuser 1.
4. Back-pressure:
   - Stream 20 back-to-back vectors while m_axis_result_tready toggles 1,0,0,1,…
   - All 20 results emerge in order with no loss or duplication, and data is stable while stalled.
   - With ready held 1, there is one result per cycle.
5. Non-power-of-two configuration, N=5 and SIZE=32 (EXP_W=8):
   - Minimum at lane 4 (the pass-through lane), value -3.0 = 32'hC0400000.
   - Result index 4 after 3 cycles.
6. Reset mid-stream:
   - Assert aresetn low with 3 vectors in flight: tvalid drops to 0 immediately and tready = 0.
   - After release, no stale results appear; the next vector's result is correct at the nominal latency.
